// File: rtl/filter_pass_seq_if.sv
// ---------------------------------------------------------------------------
// filter_pass_seq_if : control and address bus of the filter-pass sequencer
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface filter_pass_seq_if;
  logic        start_in;
  logic        abort_in;
  logic [2:0]  filter_select_in;
  logic [1:0]  threshold_select_in;
  logic        freeze_out;
  logic        rd_en_out;
  logic [16:0] rd_addr_out;
  logic [8:0]  x_out;
  logic [7:0]  y_out;
  logic        wr_en_out;
  logic [16:0] wr_addr_out;
  logic [2:0]  filter_select_out;
  logic [1:0]  threshold_select_out;
  logic        busy_out;
  logic        done_out;

  // Sequencer side
  modport master (
    input  start_in, abort_in, filter_select_in, threshold_select_in,
    output freeze_out, rd_en_out, rd_addr_out, x_out, y_out,
           wr_en_out, wr_addr_out, filter_select_out, threshold_select_out,
           busy_out, done_out
  );

  // Screen / datapath side
  modport slave (
    output start_in, abort_in, filter_select_in, threshold_select_in,
    input  freeze_out, rd_en_out, rd_addr_out, x_out, y_out,
           wr_en_out, wr_addr_out, filter_select_out, threshold_select_out,
           busy_out, done_out
  );
endinterface

`default_nettype wire

// File: rtl/filter_pass_seq.sv
// ---------------------------------------------------------------------------
// filter_pass_seq : one raster filter pass over the frame buffer, with
//                   matching delayed write strobe/address for the result buffer
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module filter_pass_seq #(
  parameter int WIDTH      = 320,
  parameter int HEIGHT     = 240,
  parameter int RD_LAT     = 2,
  parameter int PIPE_LAT   = 6,
  parameter int FREEZE_CYC = 4
) (
  input  wire logic       clk_in,
  input  wire logic       rst_in,
  filter_pass_seq_if.master io
);

  localparam int L     = RD_LAT + PIPE_LAT;
  localparam int N     = WIDTH * HEIGHT;
  localparam int FRZ_W = (FREEZE_CYC > 1) ? $clog2(FREEZE_CYC) : 1;

  localparam logic [16:0]      c_last_addr = 17'(N - 1);
  localparam logic [8:0]       c_x_last    = 9'(WIDTH - 1);
  localparam logic [FRZ_W-1:0] c_frz_last  = FRZ_W'(FREEZE_CYC - 1);
  // Every delay-line stage except the output one
  localparam logic [L-1:0]     c_head_mask = L'((64'd1 << (L - 1)) - 64'd1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FREEZE = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [FRZ_W-1:0]  frz_cnt_q, frz_cnt_d;
  logic              rd_en_q, rd_en_d;
  logic [16:0]       rd_addr_q, rd_addr_d;
  logic [8:0]        x_q, x_d;
  logic [7:0]        y_q, y_d;
  logic [2:0]        fsel_q, fsel_d;
  logic [1:0]        tsel_q, tsel_d;
  logic              busy_q, busy_d;
  logic              freeze_q, freeze_d;
  logic              done_q, done_d;
  logic [L-1:0]      pipe_vld_q, pipe_vld_d;
  logic [16:0]       pipe_addr_q [L];
  logic [16:0]       pipe_addr_d [L];

  logic w_abort;
  logic w_drain_empty;

  assign w_abort       = io.abort_in && (state_q != ST_IDLE);
  // Last valid entry is in the output stage: it leaves on this edge
  assign w_drain_empty = ((pipe_vld_q & c_head_mask) == '0);

  always_comb begin
    state_d   = state_q;
    frz_cnt_d = frz_cnt_q;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    x_d       = x_q;
    y_d       = y_q;
    fsel_d    = fsel_q;
    tsel_d    = tsel_q;

    case (state_q)
      ST_IDLE: begin
        if (io.start_in && !io.abort_in) begin
          state_d   = ST_FREEZE;
          frz_cnt_d = '0;
          fsel_d    = io.filter_select_in;
          tsel_d    = io.threshold_select_in;
        end
      end
      ST_FREEZE: begin
        if (frz_cnt_q == c_frz_last) begin
          state_d   = ST_ISSUE;
          rd_en_d   = 1'b1;
          rd_addr_d = '0;
          x_d       = '0;
          y_d       = '0;
        end else begin
          frz_cnt_d = frz_cnt_q + FRZ_W'(1);
        end
      end
      ST_ISSUE: begin
        if (rd_addr_q == c_last_addr) begin
          state_d = ST_DRAIN;
        end else begin
          rd_en_d   = 1'b1;
          rd_addr_d = rd_addr_q + 17'd1;
          if (x_q == c_x_last) begin
            x_d = '0;
            y_d = y_q + 8'd1;
          end else begin
            x_d = x_q + 9'd1;
          end
        end
      end
      ST_DRAIN: begin
        if (w_drain_empty) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (w_abort) begin
      state_d = ST_IDLE;
      rd_en_d = 1'b0;
    end

    busy_d   = (state_d == ST_FREEZE) || (state_d == ST_ISSUE) || (state_d == ST_DRAIN);
    freeze_d = busy_d;
    done_d   = (state_d == ST_DONE);
  end

  // Write-side delay line: pure L-cycle delay of the issued read
  always_comb begin
    pipe_vld_d[0]  = rd_en_q;
    pipe_addr_d[0] = rd_addr_q;
    for (int i = 1; i < L; i++) begin
      pipe_vld_d[i]  = pipe_vld_q[i-1];
      pipe_addr_d[i] = pipe_addr_q[i-1];
    end
    if (w_abort) begin
      pipe_vld_d = '0;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= ST_IDLE;
      frz_cnt_q  <= '0;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      x_q        <= '0;
      y_q        <= '0;
      fsel_q     <= '0;
      tsel_q     <= '0;
      busy_q     <= 1'b0;
      freeze_q   <= 1'b0;
      done_q     <= 1'b0;
      pipe_vld_q <= '0;
      for (int i = 0; i < L; i++) begin
        pipe_addr_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      frz_cnt_q  <= frz_cnt_d;
      rd_en_q    <= rd_en_d;
      rd_addr_q  <= rd_addr_d;
      x_q        <= x_d;
      y_q        <= y_d;
      fsel_q     <= fsel_d;
      tsel_q     <= tsel_d;
      busy_q     <= busy_d;
      freeze_q   <= freeze_d;
      done_q     <= done_d;
      pipe_vld_q <= pipe_vld_d;
      for (int i = 0; i < L; i++) begin
        pipe_addr_q[i] <= pipe_addr_d[i];
      end
    end
  end

  assign io.freeze_out           = freeze_q;
  assign io.rd_en_out            = rd_en_q;
  assign io.rd_addr_out          = rd_addr_q;
  assign io.x_out                = x_q;
  assign io.y_out                = y_q;
  assign io.wr_en_out            = pipe_vld_q[L-1];
  assign io.wr_addr_out          = pipe_addr_q[L-1];
  assign io.filter_select_out    = fsel_q;
  assign io.threshold_select_out = tsel_q;
  assign io.busy_out             = busy_q;
  assign io.done_out             = done_q;

endmodule

`default_nettype wire

// File: tb/tb_filter_pass_seq.sv
// ---------------------------------------------------------------------------
// tb_filter_pass_seq : directed bench, one full-size and one 4x3 sequencer
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_filter_pass_seq;

  localparam int FW = 320;
  localparam int FH = 240;
  localparam int FN = FW * FH;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  filter_pass_seq_if bf ();
  filter_pass_seq_if bs ();

  filter_pass_seq u_full (
    .clk_in (clk),
    .rst_in (rst),
    .io     (bf.master)
  );

  filter_pass_seq #(.WIDTH(4), .HEIGHT(3)) u_small (
    .clk_in (clk),
    .rst_in (rst),
    .io     (bs.master)
  );

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, want completion");
    $fatal(1);
  end

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_total++;
    if ({bf.freeze_out, bf.rd_en_out, bf.rd_addr_out, bf.x_out, bf.y_out, bf.wr_en_out,
         bf.wr_addr_out, bf.filter_select_out, bf.threshold_select_out, bf.busy_out,
         bf.done_out} !== '0)
      $display("FAIL reset_full: outputs not all zero (busy=%b rd_en=%b)", bf.busy_out, bf.rd_en_out);
    else n_pass++;
    n_total++;
    if ({bs.freeze_out, bs.rd_en_out, bs.rd_addr_out, bs.x_out, bs.y_out, bs.wr_en_out,
         bs.wr_addr_out, bs.filter_select_out, bs.threshold_select_out, bs.busy_out,
         bs.done_out} !== '0)
      $display("FAIL reset_small: outputs not all zero (busy=%b rd_en=%b)", bs.busy_out, bs.rd_en_out);
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_abort;
    logic found = 1'b0;
    int   n_done = 0, n_wr = 0;
    bf.start_in = 1'b1; bf.filter_select_in = 3'd5; bf.threshold_select_in = 2'd2;
    @(negedge clk);
    bf.start_in = 1'b0;
    for (int c = 0; c < 1000 && !found; c++) begin
      if (bf.rd_en_out && bf.rd_addr_out == 17'd500) found = 1'b1;
      else @(negedge clk);
    end
    n_total++;
    if (found !== 1'b1) $display("FAIL abort_reach500: got found=%b, want 1", found);
    else n_pass++;
    bf.abort_in = 1'b1;
    @(negedge clk);
    bf.abort_in = 1'b0;
    n_total++;
    if ({bf.rd_en_out, bf.wr_en_out, bf.busy_out, bf.freeze_out} !== 4'b0000)
      $display("FAIL abort_outputs: got rd/wr/busy/freeze=%b, want 0000",
               {bf.rd_en_out, bf.wr_en_out, bf.busy_out, bf.freeze_out});
    else n_pass++;
    for (int c = 0; c < 30; c++) begin
      if (bf.done_out) n_done++;
      if (bf.wr_en_out) n_wr++;
      @(negedge clk);
    end
    n_total++;
    if (n_done !== 0) $display("FAIL abort_no_done: got %0d done pulses, want 0", n_done);
    else n_pass++;
    n_total++;
    if (n_wr !== 0) $display("FAIL abort_no_wr: got %0d wr cycles, want 0", n_wr);
    else n_pass++;
  endtask

  // Full-size pass; start is re-pulsed with a new filter at ISSUE address 100
  task automatic test_full_pass;
    int rd_first = -1, rd_last = -1, rd_cnt = 0, addr_err = 0;
    int wr_first = -1, wr_last = -1, wr_cnt = 0, waddr_err = 0;
    int done_cnt = 0, done_cyc = -1, sel_err = 0, busy_err = 0;
    logic [1:0] bf_at_done = 2'b11, bf_at_1 = 2'b00;
    bf.start_in = 1'b1; bf.filter_select_in = 3'd5; bf.threshold_select_in = 2'd2;
    @(negedge clk);
    bf.start_in = 1'b0;
    for (int c = 1; c <= FN + 30; c++) begin
      if (c == 1) bf_at_1 = {bf.busy_out, bf.freeze_out};
      if (bf.rd_en_out) begin
        if (rd_first < 0) rd_first = c;
        if (bf.rd_addr_out != 17'(rd_cnt) || bf.x_out != 9'(rd_cnt % FW) ||
            bf.y_out != 8'(rd_cnt / FW)) addr_err++;
        rd_last = c; rd_cnt++;
      end
      if (bf.wr_en_out) begin
        if (wr_first < 0) wr_first = c;
        if (bf.wr_addr_out != 17'(wr_cnt)) waddr_err++;
        wr_last = c; wr_cnt++;
      end
      if (bf.done_out) begin
        done_cnt++; done_cyc = c; bf_at_done = {bf.busy_out, bf.freeze_out};
      end
      if (c <= 76813 && (bf.filter_select_out != 3'd5 || bf.threshold_select_out != 2'd2)) sel_err++;
      if (c <= 76812 && bf.busy_out !== 1'b1) busy_err++;
      if (c == 105) begin bf.start_in = 1'b1; bf.filter_select_in = 3'd1; end
      if (c == 106) begin bf.start_in = 1'b0; bf.filter_select_in = 3'd5; end
      @(negedge clk);
    end
    n_total++; if (bf_at_1 !== 2'b11) $display("FAIL full_busy_c1: got %b, want 11", bf_at_1); else n_pass++;
    n_total++; if (rd_first !== 5) $display("FAIL full_rd_first: got %0d, want 5", rd_first); else n_pass++;
    n_total++; if (rd_cnt !== FN) $display("FAIL full_rd_cnt: got %0d, want %0d", rd_cnt, FN); else n_pass++;
    n_total++; if (rd_last !== 76804) $display("FAIL full_rd_last: got %0d, want 76804", rd_last); else n_pass++;
    n_total++; if (addr_err !== 0) $display("FAIL full_rd_addr_xy: got %0d bad cycles, want 0", addr_err); else n_pass++;
    n_total++; if (wr_first !== 13) $display("FAIL full_wr_first: got %0d, want 13", wr_first); else n_pass++;
    n_total++; if (wr_cnt !== FN) $display("FAIL full_wr_cnt: got %0d, want %0d", wr_cnt, FN); else n_pass++;
    n_total++; if (wr_last !== 76812) $display("FAIL full_wr_last: got %0d, want 76812", wr_last); else n_pass++;
    n_total++; if (waddr_err !== 0) $display("FAIL full_wr_addr: got %0d bad cycles, want 0", waddr_err); else n_pass++;
    n_total++; if (done_cnt !== 1) $display("FAIL full_done_cnt: got %0d, want 1", done_cnt); else n_pass++;
    n_total++; if (done_cyc !== 76813) $display("FAIL full_done_cyc: got %0d, want 76813", done_cyc); else n_pass++;
    n_total++; if (bf_at_done !== 2'b00) $display("FAIL full_busy_at_done: got %b, want 00", bf_at_done); else n_pass++;
    n_total++; if (sel_err !== 0) $display("FAIL full_sel_hold: got %0d bad cycles, want 0", sel_err); else n_pass++;
    n_total++; if (busy_err !== 0) $display("FAIL full_busy_hold: got %0d low cycles, want 0", busy_err); else n_pass++;
  endtask

  task automatic test_raster;
    logic        rd_v [0:40];
    logic [16:0] rd_a [0:40];
    int rd_first = -1, rd_last = -1, rd_cnt = 0, xy_err = 0, wr_err = 0;
    int done_cnt = 0, done_cyc = -1;
    bs.start_in = 1'b1; bs.filter_select_in = 3'd6; bs.threshold_select_in = 2'd1;
    @(negedge clk);
    bs.start_in = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      rd_v[c] = bs.rd_en_out;
      rd_a[c] = bs.rd_addr_out;
      if (bs.rd_en_out) begin
        if (rd_first < 0) rd_first = c;
        if (bs.rd_addr_out != 17'(rd_cnt) || bs.x_out != 9'(rd_cnt % 4) ||
            bs.y_out != 8'(rd_cnt / 4)) xy_err++;
        rd_last = c; rd_cnt++;
      end
      if (c <= 8) begin
        if (bs.wr_en_out !== 1'b0) wr_err++;
      end else if (bs.wr_en_out !== rd_v[c-8] || (bs.wr_en_out && bs.wr_addr_out != rd_a[c-8])) begin
        wr_err++;
      end
      if (bs.done_out) begin done_cnt++; done_cyc = c; end
      @(negedge clk);
    end
    n_total++; if (rd_first !== 5) $display("FAIL raster_rd_first: got %0d, want 5", rd_first); else n_pass++;
    n_total++; if (rd_cnt !== 12) $display("FAIL raster_rd_cnt: got %0d, want 12", rd_cnt); else n_pass++;
    n_total++; if (rd_last !== 16) $display("FAIL raster_rd_last: got %0d, want 16", rd_last); else n_pass++;
    n_total++; if (xy_err !== 0) $display("FAIL raster_xy: got %0d bad cycles, want 0", xy_err); else n_pass++;
    n_total++; if (wr_err !== 0) $display("FAIL raster_wr_delay: got %0d bad cycles, want 0", wr_err); else n_pass++;
    n_total++; if (done_cnt !== 1) $display("FAIL raster_done_cnt: got %0d, want 1", done_cnt); else n_pass++;
    n_total++; if (done_cyc !== 25) $display("FAIL raster_done_cyc: got %0d, want 25", done_cyc); else n_pass++;
  endtask

  task automatic test_abort_start_idle;
    bs.abort_in = 1'b1; bs.start_in = 1'b1;
    bs.filter_select_in = 3'd2; bs.threshold_select_in = 2'd3;
    @(negedge clk);
    bs.abort_in = 1'b0; bs.start_in = 1'b0;
    n_total++;
    if (bs.busy_out !== 1'b0) $display("FAIL idle_abort_start_busy: got %b, want 0", bs.busy_out);
    else n_pass++;
    n_total++;
    if ({bs.filter_select_out, bs.threshold_select_out} !== {3'd6, 2'd1})
      $display("FAIL idle_abort_start_sel: got %0d/%0d, want 6/1", bs.filter_select_out, bs.threshold_select_out);
    else n_pass++;
    repeat (6) @(negedge clk);
    n_total++;
    if (bs.rd_en_out !== 1'b0) $display("FAIL idle_abort_start_rd: got %b, want 0", bs.rd_en_out);
    else n_pass++;
  endtask

  task automatic test_reset_drain;
    int   n_wr = 0, n_done = 0;
    logic wr_before;
    bs.start_in = 1'b1; bs.filter_select_in = 3'd6; bs.threshold_select_in = 2'd1;
    @(negedge clk);
    bs.start_in = 1'b0;
    repeat (18) @(negedge clk);   // now in cycle 19, inside DRAIN
    wr_before = bs.wr_en_out;
    n_total++;
    if (wr_before !== 1'b1) $display("FAIL drain_wr_before_rst: got %b, want 1", wr_before);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_total++;
    if ({bs.freeze_out, bs.rd_en_out, bs.rd_addr_out, bs.x_out, bs.y_out, bs.wr_en_out,
         bs.wr_addr_out, bs.filter_select_out, bs.threshold_select_out, bs.busy_out,
         bs.done_out} !== '0)
      $display("FAIL drain_async_rst: got wr=%b busy=%b freeze=%b, want all zero",
               bs.wr_en_out, bs.busy_out, bs.freeze_out);
    else n_pass++;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (bs.wr_en_out) n_wr++;
      if (bs.done_out) n_done++;
      @(negedge clk);
    end
    n_total++; if (n_wr !== 0) $display("FAIL drain_post_rst_wr: got %0d, want 0", n_wr); else n_pass++;
    n_total++; if (n_done !== 0) $display("FAIL drain_post_rst_done: got %0d, want 0", n_done); else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic prev = 1'b0, busy26 = 1'b1, busy27 = 1'b0;
    int   fall1 = -1, rise2 = -1, n_rise = 0, d1 = -1, d2 = -1;
    bs.start_in = 1'b1; bs.filter_select_in = 3'd3;
    @(negedge clk);
    for (int c = 1; c <= 55; c++) begin
      if (bs.rd_en_out && !prev) begin
        n_rise++;
        if (n_rise == 2) rise2 = c;
      end
      if (!bs.rd_en_out && prev && fall1 < 0) fall1 = c - 1;
      prev = bs.rd_en_out;
      if (bs.done_out) begin
        if (d1 < 0) d1 = c;
        else if (d2 < 0) d2 = c;
      end
      if (c == 26) busy26 = bs.busy_out;
      if (c == 27) busy27 = bs.busy_out;
      @(negedge clk);
    end
    bs.start_in = 1'b0;
    n_total++; if (rise2 - fall1 - 1 !== 14) $display("FAIL b2b_gap: got %0d, want 14", rise2 - fall1 - 1); else n_pass++;
    n_total++; if (d1 !== 25) $display("FAIL b2b_done1: got %0d, want 25", d1); else n_pass++;
    n_total++; if (d2 !== 51) $display("FAIL b2b_done2: got %0d, want 51", d2); else n_pass++;
    n_total++; if ({busy26, busy27} !== 2'b01) $display("FAIL b2b_accept: got busy26/27=%b, want 01", {busy26, busy27}); else n_pass++;
    repeat (40) @(negedge clk);
  endtask

  initial begin
    bf.start_in = 1'b0; bf.abort_in = 1'b0; bf.filter_select_in = '0; bf.threshold_select_in = '0;
    bs.start_in = 1'b0; bs.abort_in = 1'b0; bs.filter_select_in = '0; bs.threshold_select_in = '0;
    test_reset();
    test_abort();
    test_full_pass();
    test_raster();
    test_abort_start_idle();
    test_reset_drain();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/filter_pass_seq.md
# filter_pass_seq

Sequencer that runs one complete filter pass over the 320x240 grayscale frame buffer once the selection screen reports that the user has finished choosing. On a start pulse it freezes camera writes into the buffer and latches the filter and threshold selections. It then issues every read address once, in raster order, to the buffer's 65 MHz read port. It also produces the matching write strobe and address for the result buffer, delayed by the combined read and filter latency. It sits between the screen state machine and the frame-buffer/filter datapath.

## Interface
Parameters:
- WIDTH, 320, pixels per line.
- HEIGHT, 240, lines per frame.
- RD_LAT, 2, frame-buffer read latency in cycles (address to data).
- PIPE_LAT, 6, filter pipeline latency in cycles (data in to data out).
- FREEZE_CYC, 4, cycles to hold freeze before the first read, to let an in-flight camera write land.

Ports:
- clk_in, input, 1, 65 MHz system clock.
- rst_in, input, 1, reset; asynchronous, active-high.
- start_in, input, 1, request a pass; honoured only in IDLE.
- abort_in, input, 1, synchronous abort of a pass in progress.
- filter_select_in, input, 3, filter choice from the screen module.
- threshold_select_in, input, 2, threshold choice from the screen module.
- freeze_out, output, 1, high blocks camera writes (gates wea).
- rd_en_out, output, 1, read-address valid.
- rd_addr_out, output, 17, read address, y*WIDTH + x.
- x_out, output, 9, column of the current read.
- y_out, output, 8, row of the current read.
- wr_en_out, output, 1, result-buffer write strobe.
- wr_addr_out, output, 17, result-buffer address.
- filter_select_out, output, 3, selection latched at start.
- threshold_select_out, output, 2, selection latched at start.
- busy_out, output, 1, high from start acceptance until done.
- done_out, output, 1, one-cycle pulse at pass completion.

## Operation
- L = RD_LAT + PIPE_LAT. N = WIDTH*HEIGHT, which is 76800 with the defaults.
- All outputs are registered. Every output resets to 0.
- The state machine has five states: IDLE, FREEZE, ISSUE, DRAIN, DONE.
- IDLE:
  - start_in=1 moves to FREEZE.
  - filter_select_in and threshold_select_in are latched in the same cycle.
  - busy_out=1 and freeze_out=1 from the next cycle.
- FREEZE: stays for exactly FREEZE_CYC cycles, then moves to ISSUE.
- ISSUE:
  - rd_en_out=1 for exactly N consecutive cycles.
  - Addresses run 0,1,…,N-1.
  - x_out and y_out track the address: x wraps from WIDTH-1 to 0 and y increments on that wrap.
  - After the cycle carrying address N-1, moves to DRAIN.
- DRAIN: waits until the delay line is empty, then moves to DONE.
- DONE:
  - done_out=1 for one cycle; busy_out=0 and freeze_out=0 in that same cycle.
  - Then returns to IDLE.
- Write side is an L-deep shift register of {rd_en_out, rd_addr_out}. Its output drives wr_en_out and wr_addr_out, so wr_addr_out equals the rd_addr_out issued L cycles earlier.
- Latched selections hold their value through the whole pass and until the next accepted start.
- start_in while not IDLE is ignored: no restart and no relatch.
- abort_in has priority over start_in:
  - In any non-IDLE state, abort_in=1 returns to IDLE on the next edge.
  - In that same cycle it clears the delay line (wr_en_out=0), drops rd_en_out, busy_out and freeze_out, and suppresses done_out.
- abort_in and start_in high together in IDLE: start is ignored.
- rst_in mid-pass: immediate return to IDLE with all outputs 0. No residual writes after release.
- rd_addr_out, x_out and y_out hold their last value when rd_en_out=0. Consumers qualify them with rd_en_out.

## Timing
- Cycle 0 is the edge that samples start_in=1.
- Cycle 1: busy_out=1, freeze_out=1.
- Cycle 1+FREEZE_CYC: first rd_en_out=1 with address 0.
- Cycle FREEZE_CYC+N: last rd_en_out=1 with address N-1.
- Cycle 1+FREEZE_CYC+L: first wr_en_out=1 with address 0.
- Cycle FREEZE_CYC+N+L: last wr_en_out=1.
- Cycle FREEZE_CYC+N+L+1: done_out=1 and busy_out=0.
- With defaults, done occurs at cycle 76813.
- Throughput is one pixel per cycle with no gaps. wr_en_out is a pure L-cycle delay of rd_en_out.
- Earliest next start is accepted in the cycle after done_out.

## Test plan
- Default parameters: reset, then pulse start with filter_select_in=3'd5 and threshold_select_in=2'd2.
  - rd_en_out high 76800 consecutive cycles starting at cycle 5.
  - wr_en_out high 76800 cycles starting at cycle 13.
  - done_out single pulse at cycle 76813.
  - Selection outputs hold 5 and 2 throughout.
- Raster check with WIDTH=4, HEIGHT=3:
  - (x,y) sequence is (0,0),(1,0),(2,0),(3,0),(0,1),…,(3,2).
  - rd_addr_out runs 0..11.
  - wr_addr_out equals rd_addr_out from L cycles earlier on every wr_en_out cycle.
- Start re-pulsed at ISSUE cycle 100 with filter_select_in changed to 3'd1:
  - Pass unaffected and no restart.
  - filter_select_out stays 5.
  - Exactly one done_out.
- abort_in pulsed at ISSUE address 500:
  - Next cycle rd_en_out, wr_en_out, busy_out and freeze_out are all 0.
  - No done_out.
  - A following start runs a full, clean pass.
- rst_in asserted asynchronously mid-DRAIN, between clock edges:
  - All outputs go to 0 without waiting for an edge.
  - After release no wr_en_out pulses and no done_out until a new start.
- Back-to-back operation: start held high continuously.
  - A new pass is accepted on the cycle after done_out.
  - The gap between the two passes' rd_en_out bursts is exactly FREEZE_CYC+L+2 cycles.
